pipeline_hazard_unit: RTL and testbench
=======================================

// Module: pipeline_hazard_unit
// PURPOSE
//   Sequencing controller for the 5-stage fetch/decode/execute/memory/writeback pipeline.
//   Tracks the destination register of every in-flight instruction in EX/MEM/WB (scoreboard),
//   detects load-use hazards and taken-branch redirects, and drives stall, bubble, flush
//   and operand-forwarding selects for the ALU input muxes. Also counts stall cycles for perf.
// PARAMETERS
//   FLUSH_SLOTS  2   decode cycles killed after a taken branch/jump redirect (1..3)
//   CNT_W        32  width of stall_cycles perf counter
// PORTS
//   clk           in   1      pipeline clock, all state on rising edge
//   reset         in   1      asynchronous, active-low; 0 clears all state immediately
//   id_valid      in   1      decode buffer holds a real instruction
//   id_rs1        in   5      decode rs1 address
//   id_rs2        in   5      decode rs2 address
//   id_uses_rs1   in   1      decoded instruction reads rs1
//   id_uses_rs2   in   1      decoded instruction reads rs2
//   id_rd         in   5      decode rd address
//   id_regwrite   in   1      decoded instruction writes rd
//   id_is_load    in   1      decoded instruction is a load (result only at MEM)
//   br_taken      in   1      decode resolved a redirect (pcsel != sequential)
//   stall_if      out  1      hold pc register and decode buffer this cycle
//   bubble_ex     out  1      load a NOP into the execute buffers this cycle
//   flush_id      out  1      kill the instruction in the decode buffer
//   fwd_a         out  2      rs1 source: 00 regbank, 01 ALU out (EX), 10 mem mux (MEM), 11 writeback
//   fwd_b         out  2      rs2 source, same encoding
//   stall_cycles  out  CNT_W  saturating count of cycles with stall_if=1
// BEHAVIOUR
//   - Scoreboard: entries EX, MEM, WB = {valid, rd, regwrite, is_load}; reset: all valid=0.
//     Every clock: WB<=MEM, MEM<=EX; EX<=ID entry with valid=id_valid & ~bubble_ex.
//   - match(S,r) = S.valid & S.regwrite & S.rd==r & r!=0. x0 never matches/forwards/stalls.
//   - Load-use: stall = (match(EX,id_rs1)&id_uses_rs1 | match(EX,id_rs2)&id_uses_rs2)
//     & EX.is_load & id_valid & ~flush_id. Exactly 1 cycle per load (load moves to MEM).
//   - Forward, priority EX > MEM > WB per operand, gated by id_uses_rsN: 01/10/11; else 00.
//     While stall=1 fwd outputs are don't-care-but-deterministic (same formula).
//   - stall_if = stall; bubble_ex = stall | flush_id. All three combinational from state+inputs.
//   - Flush FSM: IDLE -> FLUSH on (br_taken & ~stall & ~flush_id), loads cnt=FLUSH_SLOTS-1;
//     FLUSH: flush_id=1, cnt decrements, FLUSH -> IDLE when cnt==0 at clock edge.
//     flush_id asserted for exactly FLUSH_SLOTS cycles starting the cycle after br_taken.
//   - br_taken ignored while stall=1 (branch re-presented next cycle) or flush_id=1 (wrong path).
//   - Flush beats stall: stall term is masked by flush_id.
//   - stall_cycles += 1 each clock with stall_if=1; holds at all-ones, never wraps.
//   - Reset mid-flush/mid-stall: FSM->IDLE, cnt=0, scoreboard invalid, counter 0; all outputs 0.
//   - Latency: hazard outputs zero-cycle (same cycle as decode inputs); scoreboard 1 cycle/stage.
// TESTING
//   1. Reset=0 during FLUSH with stall pending -> same cycle stall_if=flush_id=bubble_ex=0, fwd=00, stall_cycles=0.
//   2. EX: addi rd=5; ID: rs1=5 uses -> fwd_a=01, stall_if=0; next cycle fwd_a=10, then 11, then 00.
//   3. EX: lw rd=7; ID: rs2=7 uses -> stall_if=1,bubble_ex=1 one cycle; next cycle fwd_b=10, stall_cycles=1.
//   4. EX rd=0 regwrite, ID rs1=rs2=0 -> fwd_a=fwd_b=00, no stall; load to x0 -> no stall.
//   5. br_taken 1-cycle pulse, FLUSH_SLOTS=2 -> flush_id=1 exactly 2 cycles; 2nd br_taken inside ignored;
//      flushed slots enter EX with valid=0 (no forwarding from them).
//   6. EX,MEM,WB all rd=3, ID rs1=3 -> fwd_a=01; EX invalid -> 10; only WB -> 11; CNT_W=4, 20 stalls -> 15.

Source files
------------

// File: rtl/pipeline_hazard_unit.sv
// Hazard and sequencing controller for the 5-stage pipeline.
// A three-deep scoreboard follows the destination register of each instruction
// in EX/MEM/WB. Load-use stalls, branch flushes and ALU operand-forwarding
// selects are all derived combinationally from that scoreboard and the decode
// fields. A saturating counter records the number of stall cycles.
module pipeline_hazard_unit #(
    parameter int FLUSH_SLOTS = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_regwrite,
    input  logic             id_is_load,
    input  logic             br_taken,
    output logic             stall_if,
    output logic             bubble_ex,
    output logic             flush_id,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       is_load;
    } sb_entry_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } flush_state_t;

    // The slot count is 1..3, so a 2-bit down-counter is sufficient.
    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_SLOTS - 1);

    sb_entry_t    ex_r, mem_r, wb_r;
    sb_entry_t    ex_nxt_s;
    flush_state_t state_r, state_nxt_s;
    logic [1:0]   cnt_r, cnt_nxt_s;
    logic [CNT_W-1:0] stall_cycles_r;
    logic         load_use_s;
    logic         stall_s;
    logic         flush_s;

    // A scoreboard entry is a forwarding source for register r only if it writes r,
    // and never when r is x0.
    function automatic logic sb_match(input sb_entry_t e, input logic [4:0] r);
        return e.valid & e.regwrite & (e.rd == r) & (r != 5'd0);
    endfunction

    // Select the operand source with EX > MEM > WB priority; 00 is the register bank.
    function automatic logic [1:0] fwd_sel(input logic uses, input logic [4:0] r,
                                           input sb_entry_t ex, input sb_entry_t mem,
                                           input sb_entry_t wb);
        logic [1:0] sel;
        sel = 2'b00;
        if (!uses) begin
            sel = 2'b00;
        end else if (sb_match(ex, r)) begin
            sel = 2'b01;
        end else if (sb_match(mem, r)) begin
            sel = 2'b10;
        end else if (sb_match(wb, r)) begin
            sel = 2'b11;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Hazard detection: a load in EX feeding a decode operand stalls, unless decode is being flushed.
    always_comb begin
        flush_s    = (state_r == ST_FLUSH);
        load_use_s = ((sb_match(ex_r, id_rs1) & id_uses_rs1) |
                      (sb_match(ex_r, id_rs2) & id_uses_rs2)) &
                     ex_r.is_load & id_valid;
        stall_s    = load_use_s & ~flush_s;
        stall_if   = stall_s;
        flush_id   = flush_s;
        bubble_ex  = stall_s | flush_s;
        fwd_a      = fwd_sel(id_uses_rs1, id_rs1, ex_r, mem_r, wb_r);
        fwd_b      = fwd_sel(id_uses_rs2, id_rs2, ex_r, mem_r, wb_r);
    end

    // The decode instruction enters EX as a real entry only if it is not replaced by a bubble.
    always_comb begin
        ex_nxt_s = {id_valid & ~bubble_ex, id_rd, id_regwrite, id_is_load};
    end

    // Flush sequencer: an accepted redirect kills the next FLUSH_SLOTS decode cycles.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (br_taken & ~stall_s) begin
                    state_nxt_s = ST_FLUSH;
                    cnt_nxt_s   = FLUSH_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (cnt_r == 2'd0) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    cnt_nxt_s = cnt_r - 2'd1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 2'd0;
            end
        endcase
    end

    // Flush sequencer state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 2'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Scoreboard shift: ID -> EX -> MEM -> WB, one stage per clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_r  <= '0;
            mem_r <= '0;
            wb_r  <= '0;
        end else begin
            ex_r  <= ex_nxt_s;
            mem_r <= ex_r;
            wb_r  <= mem_r;
        end
    end

    // Saturating stall-cycle counter: holds at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_r <= '0;
        end else if (stall_s && (stall_cycles_r != {CNT_W{1'b1}})) begin
            stall_cycles_r <= stall_cycles_r + CNT_W'(1);
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

    assign stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Bench for pipeline_hazard_unit: directed scenarios followed by random traffic.
// The driver predicts each cycle's outputs from a list of in-flight instructions
// and queues the prediction. A monitor pops each prediction at the falling edge
// and compares it against the DUT.
module tb_pipeline_hazard_unit;

    localparam int FS = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          id_valid = 1'b0, id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
    logic [4:0]    id_rs1 = 5'd0, id_rs2 = 5'd0, id_rd = 5'd0;
    logic          id_regwrite = 1'b0, id_is_load = 1'b0, br_taken = 1'b0;
    logic          stall_if, bubble_ex, flush_id;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] stall_cycles;

    pipeline_hazard_unit #(.FLUSH_SLOTS(FS), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_is_load(id_is_load), .br_taken(br_taken),
        .stall_if(stall_if), .bubble_ex(bubble_ex), .flush_id(flush_id),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct { bit valid; bit [4:0] rd; bit rw; bit ld; } instr_t;
    typedef struct { bit stall; bit bubble; bit flush; int fa; int fb; int cnt; } exp_t;

    // Reference state: in-flight instructions, youngest (EX) first.
    instr_t inflight[$];
    int     flush_left;
    int     stall_cnt;
    bit     last_stall;
    exp_t   exp_q[$];
    int     checks = 0;
    int     errors = 0;
    bit     done = 1'b0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_clear();
        instr_t e;
        e = '{valid: 1'b0, rd: 5'd0, rw: 1'b0, ld: 1'b0};
        inflight = {};
        repeat (3) inflight.push_back(e);
        flush_left = 0;
        stall_cnt  = 0;
        last_stall = 1'b0;
    endtask

    // Pipeline distance (1=EX, 2=MEM, 3=WB) of the youngest producer of r, 0 if none.
    function automatic int src_of(input bit uses, input bit [4:0] r);
        if (!uses || r == 5'd0) return 0;
        for (int i = 0; i < 3; i++)
            if (inflight[i].valid && inflight[i].rw && inflight[i].rd == r) return i + 1;
        return 0;
    endfunction

    // Drive one decode cycle, queue the predicted outputs, then advance the model by one clock.
    task automatic step(input bit v, input bit [4:0] rs1, input bit [4:0] rs2,
                        input bit u1, input bit u2, input bit [4:0] rd,
                        input bit rw, input bit ld, input bit br);
        exp_t   x;
        instr_t e;
        bit     fl, lu;
        @(posedge clk); #1;
        reset = 1'b1;
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        id_rd = rd; id_regwrite = rw; id_is_load = ld; br_taken = br;
        fl = (flush_left > 0);
        x.fa = src_of(u1, rs1);
        x.fb = src_of(u2, rs2);
        // A load one stage ahead cannot supply its data yet.
        lu = v && !fl && inflight[0].ld && (x.fa == 1 || x.fb == 1);
        x.stall = lu; x.bubble = lu || fl; x.flush = fl; x.cnt = stall_cnt;
        exp_q.push_back(x);
        if (lu && stall_cnt < (1 << CW) - 1) stall_cnt++;
        if (fl) flush_left--;
        else if (br && !lu) flush_left = FS;
        e = '{valid: v && !lu && !fl, rd: rd, rw: rw, ld: ld};
        inflight.push_front(e);
        void'(inflight.pop_back());
        last_stall = lu;
    endtask

    // Hold reset low for one cycle with arbitrary inputs; every output must read zero.
    task automatic reset_cycle();
        exp_t x;
        @(posedge clk); #1;
        reset = 1'b0;
        id_valid = 1'b1; id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
        id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1; id_rd = 5'd2; id_regwrite = 1'b1;
        id_is_load = 1'b1; br_taken = 1'b1;
        x = '{stall: 1'b0, bubble: 1'b0, flush: 1'b0, fa: 0, fb: 0, cnt: 0};
        exp_q.push_back(x);
        model_clear();
    endtask

    // Monitor: compare every queued prediction at the falling edge.
    initial begin
        exp_t x;
        while (!done) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("stall_if", int'(stall_if), int'(x.stall));
                chk("bubble_ex", int'(bubble_ex), int'(x.bubble));
                chk("flush_id", int'(flush_id), int'(x.flush));
                chk("fwd_a", int'(fwd_a), x.fa);
                chk("fwd_b", int'(fwd_b), x.fb);
                chk("stall_cycles", int'(stall_cycles), x.cnt);
            end
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bit [4:0] r1, r2, rd;
        bit       v, u1, u2, rw, ld, br;
        model_clear();
        reset_cycle();
        // Forwarding from ALU result through each stage: expect 01, 10, 11, 00.
        step(1, 0, 0, 0, 0, 5, 1, 0, 0);
        step(1, 5, 0, 1, 0, 0, 0, 0, 0);
        step(1, 5, 0, 1, 0, 0, 0, 0, 0);
        step(1, 5, 0, 1, 0, 0, 0, 0, 0);
        step(1, 5, 0, 1, 0, 0, 0, 0, 0);
        // Load-use on rs2: one stall, then forwarding from MEM.
        step(1, 0, 0, 0, 0, 7, 1, 1, 0);
        step(1, 0, 7, 0, 1, 8, 1, 0, 0);
        step(1, 0, 7, 0, 1, 8, 1, 0, 0);
        // x0 never forwards or stalls.
        step(1, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 1, 0, 1, 1, 0);
        step(1, 0, 0, 1, 1, 0, 0, 0, 0);
        // Branch: two flushed slots, second branch inside ignored, flushed slots do not forward.
        step(1, 0, 0, 0, 0, 9, 1, 0, 1);
        step(1, 0, 0, 0, 0, 9, 1, 0, 1);
        step(1, 0, 0, 0, 0, 9, 1, 0, 0);
        step(1, 9, 9, 1, 1, 0, 0, 0, 0);
        step(1, 9, 9, 1, 1, 0, 0, 0, 0);
        // Forward priority with rd=3 in every stage.
        step(1, 0, 0, 0, 0, 3, 1, 0, 0);
        step(1, 0, 0, 0, 0, 3, 1, 0, 0);
        step(1, 0, 0, 0, 0, 3, 1, 0, 0);
        step(1, 3, 0, 1, 0, 0, 0, 0, 0);
        step(0, 3, 0, 1, 0, 3, 1, 0, 0);
        step(1, 3, 0, 1, 0, 0, 0, 0, 0);
        // Reset while flushing with a load-use pending behind the flush.
        step(1, 0, 0, 0, 0, 7, 1, 1, 1);
        step(1, 7, 0, 1, 0, 0, 0, 0, 0);
        reset_cycle();
        step(1, 7, 0, 1, 0, 0, 0, 0, 0);
        // Twenty load-use stalls: the 4-bit counter saturates at 15.
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 0, 0, 0, 1, 1, 1, 0);
            step(1, 1, 0, 1, 0, 2, 1, 0, 0);
            step(1, 1, 0, 1, 0, 2, 1, 0, 0);
        end
        reset_cycle();
        // Random traffic; a stalled instruction is re-presented as the pipeline would hold it.
        {v, r1, r2, u1, u2, rd, rw, ld, br} = '0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                reset_cycle();
            end else begin
                if (!last_stall) begin
                    v  = ($urandom_range(0, 7) != 0);
                    r1 = 5'($urandom_range(0, 3));
                    r2 = 5'($urandom_range(0, 3));
                    u1 = 1'($urandom_range(0, 1));
                    u2 = 1'($urandom_range(0, 1));
                    rd = 5'($urandom_range(0, 3));
                    rw = ($urandom_range(0, 3) != 0);
                    ld = ($urandom_range(0, 2) == 0);
                end
                br = ($urandom_range(0, 5) == 0);
                step(v, r1, r2, u1, u2, rd, rw, ld, br);
            end
        end
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
